iommu_msi_ptw: RTL and testbench
================================

Name: iommu_msi_ptw

Overview:
MSI page-table walker for the RISC-V IOMMU translation path. It is started after a device context has been loaded and first/second-stage translation has produced a GPA page number. The block decides whether the GPA targets a virtual interrupt file (MSI pattern/mask match) and, if it does, fetches the MSI PTE over a single-outstanding 64-bit read port. It then returns either a write-through SPA PPN, MRIF parameters, or a fault cause.

Parameters:
MSI_MASK_LEN, 52, width of GPA PPN, MSI mask and MSI pattern
PPN_W, 44, width of msiptp PPN and output PPNs
PA_W, 56, physical address width of the memory read port

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
init_i  in  1  start walk; sampled only in IDLE
gppn_i  in  MSI_MASK_LEN  GPA page number (GPA>>12)
msiptp_mode_i  in  4  0=Off, 1=Flat; any other value is treated as Off
msiptp_ppn_i  in  PPN_W  MSI page table base PPN
msi_mask_i  in  MSI_MASK_LEN  MSI address mask
msi_pattern_i  in  MSI_MASK_LEN  MSI address pattern
busy_o  out  1  walk in progress (state != IDLE)
done_o  out  1  one-cycle completion pulse
hit_o  out  1  GPA is an MSI address
fault_o  out  1  walk faulted
cause_o  out  12  fault cause code
mrif_o  out  1  PTE is MRIF mode
spa_ppn_o  out  PPN_W  write-through target PPN
mrif_addr_o  out  47  MRIF address [55:9]
mrif_nppn_o  out  PPN_W  notice PPN
mrif_nid_o  out  11  notice ID
mem_req_o  out  1  read request
mem_addr_o  out  PA_W  read address, 8-byte aligned
mem_gnt_i  in  1  request accepted
mem_rvalid_i  in  1  read data valid
mem_rdata_i  in  64  read data
mem_err_i  in  1  access error, qualified by mem_rvalid_i

Behaviour:
- Reset: FSM goes to IDLE. All outputs are 0.
- The block sees one clock and one reset, and the reset is synchronous and active-high (clk_i, rst_i).
- Match rule: hit = (mode==1) && (((gppn_i ^ msi_pattern_i) & ~msi_mask_i) == 0).
- Index: idx = gppn_i bits selected by msi_mask_i, compacted toward bit 0 in ascending order.
- Base address: pte_addr = ({msiptp_ppn_i,12'b0} + (idx<<4)), truncated to PA_W bits (modulo wrap, no fault).
- Inputs are captured in IDLE on init_i and held internally for the whole walk.
- States:
  - IDLE: on init_i, if not hit, go to DONE with hit_o=0 and no memory access. If hit, go to REQ0.
  - REQ0: mem_req_o=1, mem_addr_o=pte_addr. Request and address are held stable until mem_gnt_i; on grant, go to WAIT0.
  - WAIT0: wait for mem_rvalid_i. Evaluate the low dword:
    - mem_err_i: cause 261.
    - v=0 (bit0): cause 262.
    - m (bits[2:1])==3 (write-through): c (bit63)=1, or bits[9:3]!=0, or bits[62:54]!=0, gives cause 263. Otherwise spa_ppn_o = bits[53:10].
    - m==1 (MRIF): mrif_addr_o = bits[53:7], then go to REQ1.
    - m==0 or m==2: cause 263.
    - Any fault or a write-through success goes to DONE.
  - REQ1/WAIT1: same handshake at pte_addr+8. mem_err_i gives cause 261. Otherwise mrif_nppn_o = bits[53:10], mrif_nid_o = {bit60, bits[9:0]}, mrif_o=1. Go to DONE.
  - DONE: done_o=1 for exactly one cycle, then IDLE.
- hit_o, fault_o, cause_o, spa_ppn_o and mrif_* become valid with done_o and are held until the next accepted init_i. They are cleared on that accept.
- One outstanding read only. mem_rvalid_i in IDLE, REQx or DONE is ignored.
- init_i while busy_o=1 is ignored.
- Reset mid-walk: mem_req_o drops in the same cycle the reset is sampled. A response still in flight that arrives later is ignored.
- Latency:
  - Non-MSI: done_o at T+1 after init at T.
  - Write-through with gnt at the first request cycle and rvalid the next cycle: done_o at T+3.
  - MRIF: 2 extra cycles.

Test Plan:
- Write-through hit: mask=0x7, pattern=0x28000, gppn=0x28005, msiptp=(1,0x80000). Read at 0x80000050 returning 0x48D1407 -> done at T+3, hit_o=1, fault_o=0, spa_ppn_o=0x12345, mrif_o=0.
- Miss: gppn=0x29005 with the same config -> done_o at T+1, hit_o=0, mem_req_o never asserted. Also mode=0 with a matching gppn -> same miss response.
- Invalid PTE: low dword 0x0 -> fault_o=1, cause_o=262, no second read. Low dword 0x5 (m=2) -> cause 263. mem_err_i on the first response -> cause 261.
- MRIF: low dword 0x3 | (0x1ABCDE<<7), high dword (1<<60)|(0x777<<10)|0x155. Reads at 0x80000050 then 0x80000058 -> mrif_o=1, mrif_addr_o=0x1ABCDE, mrif_nppn_o=0x777, mrif_nid_o=0x555.
- Handshake: hold mem_gnt_i low for 5 cycles -> mem_req_o and mem_addr_o stay stable throughout. A second init_i during the walk is ignored, and only one done_o pulse is produced.
- Reset in WAIT0, then rvalid with data 0x48D1407 one cycle later -> stays IDLE, no done_o, all outputs 0. A following normal walk then completes correctly.

Source files
------------

// File: rtl/iommu_msi_ptw.sv
// MSI page-table walker: decides whether a GPA page targets a virtual interrupt
// file and, if so, fetches the MSI PTE (one or two dwords) over a single
// outstanding read port, returning a write-through PPN, MRIF parameters or a fault.
module iommu_msi_ptw #(
  parameter int unsigned MSI_MASK_LEN = 52,
  parameter int unsigned PPN_W        = 44,
  parameter int unsigned PA_W         = 56
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    init_i,
  input  logic [MSI_MASK_LEN-1:0] gppn_i,
  input  logic [3:0]              msiptp_mode_i,
  input  logic [PPN_W-1:0]        msiptp_ppn_i,
  input  logic [MSI_MASK_LEN-1:0] msi_mask_i,
  input  logic [MSI_MASK_LEN-1:0] msi_pattern_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    hit_o,
  output logic                    fault_o,
  output logic [11:0]             cause_o,
  output logic                    mrif_o,
  output logic [PPN_W-1:0]        spa_ppn_o,
  output logic [46:0]             mrif_addr_o,
  output logic [PPN_W-1:0]        mrif_nppn_o,
  output logic [10:0]             mrif_nid_o,
  output logic                    mem_req_o,
  output logic [PA_W-1:0]         mem_addr_o,
  input  logic                    mem_gnt_i,
  input  logic                    mem_rvalid_i,
  input  logic [63:0]             mem_rdata_i,
  input  logic                    mem_err_i
);

  localparam int unsigned CAUSE_W     = 12;
  localparam int unsigned MRIF_ADDR_W = 47;
  localparam int unsigned NID_W       = 11;

  localparam logic [CAUSE_W-1:0] CAUSE_ACCESS  = CAUSE_W'(261);
  localparam logic [CAUSE_W-1:0] CAUSE_INVALID = CAUSE_W'(262);
  localparam logic [CAUSE_W-1:0] CAUSE_MISCONF = CAUSE_W'(263);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ0, S_WAIT0, S_REQ1, S_WAIT1, S_DONE
  } state_e;

  state_e                   state_q, state_d;
  logic                     busy_q, busy_d, done_q, done_d;
  logic                     hit_q, hit_d, fault_q, fault_d, mrif_q, mrif_d;
  logic [CAUSE_W-1:0]       cause_q, cause_d;
  logic [PPN_W-1:0]         spa_q, spa_d, nppn_q, nppn_d;
  logic [MRIF_ADDR_W-1:0]   maddr_q, maddr_d, lo_addr_q, lo_addr_d;
  logic [NID_W-1:0]         nid_q, nid_d;
  logic                     req_q, req_d;
  logic [PA_W-1:0]          addr_q, addr_d, pte_addr_q, pte_addr_d;

  logic [MSI_MASK_LEN-1:0]  idx_c;
  logic                     hit_c;
  logic [PA_W-1:0]          pte_addr_c;
  logic                     wt_bad_c;

  // Compact the mask-selected GPA bits toward bit 0 (lowest selected bit lands at bit 0).
  always_comb begin
    idx_c = '0;
    for (int i = int'(MSI_MASK_LEN) - 1; i >= 0; i--) begin
      if (msi_mask_i[i]) idx_c = {idx_c[MSI_MASK_LEN-2:0], gppn_i[i]};
    end
  end

  assign hit_c      = (msiptp_mode_i == 4'd1) &&
                      (((gppn_i ^ msi_pattern_i) & ~msi_mask_i) == '0);
  assign pte_addr_c = PA_W'({msiptp_ppn_i, 12'b0}) + PA_W'({idx_c, 4'b0});
  assign wt_bad_c   = mem_rdata_i[63] | (|mem_rdata_i[9:3]) | (|mem_rdata_i[62:54]);

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state and result/handshake updates.
  always_comb begin
    state_d    = state_q;
    hit_d      = hit_q;
    fault_d    = fault_q;
    cause_d    = cause_q;
    mrif_d     = mrif_q;
    spa_d      = spa_q;
    maddr_d    = maddr_q;
    nppn_d     = nppn_q;
    nid_d      = nid_q;
    lo_addr_d  = lo_addr_q;
    pte_addr_d = pte_addr_q;
    case (state_q)
      S_IDLE: begin
        if (init_i) begin
          hit_d      = 1'b0;
          fault_d    = 1'b0;
          cause_d    = '0;
          mrif_d     = 1'b0;
          spa_d      = '0;
          maddr_d    = '0;
          nppn_d     = '0;
          nid_d      = '0;
          lo_addr_d  = '0;
          pte_addr_d = pte_addr_c;
          state_d    = hit_c ? S_REQ0 : S_DONE;
        end
      end
      S_REQ0: if (mem_gnt_i) state_d = S_WAIT0;
      S_WAIT0: begin
        if (mem_rvalid_i) begin
          state_d = S_DONE;
          if (mem_err_i) begin
            fault_d = 1'b1;
            cause_d = CAUSE_ACCESS;
          end else if (!mem_rdata_i[0]) begin
            fault_d = 1'b1;
            cause_d = CAUSE_INVALID;
          end else if (mem_rdata_i[2:1] == 2'b11) begin
            if (wt_bad_c) begin
              fault_d = 1'b1;
              cause_d = CAUSE_MISCONF;
            end else begin
              spa_d = PPN_W'(mem_rdata_i[53:10]);
            end
          end else if (mem_rdata_i[2:1] == 2'b01) begin
            lo_addr_d = MRIF_ADDR_W'(mem_rdata_i[53:7]);
            state_d   = S_REQ1;
          end else begin
            fault_d = 1'b1;
            cause_d = CAUSE_MISCONF;
          end
          if (state_d == S_DONE) hit_d = 1'b1;
        end
      end
      S_REQ1: if (mem_gnt_i) state_d = S_WAIT1;
      S_WAIT1: begin
        if (mem_rvalid_i) begin
          state_d = S_DONE;
          hit_d   = 1'b1;
          if (mem_err_i) begin
            fault_d = 1'b1;
            cause_d = CAUSE_ACCESS;
          end else begin
            mrif_d  = 1'b1;
            maddr_d = lo_addr_q;
            nppn_d  = PPN_W'(mem_rdata_i[53:10]);
            nid_d   = {mem_rdata_i[60], mem_rdata_i[9:0]};
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
    req_d  = (state_d == S_REQ0) || (state_d == S_REQ1);
    if (state_d == S_REQ0)      addr_d = pte_addr_d;
    else if (state_d == S_REQ1) addr_d = pte_addr_q + PA_W'(8);
    else                        addr_d = '0;
  end

  // Registered outputs and walk context.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      hit_q      <= 1'b0;
      fault_q    <= 1'b0;
      cause_q    <= '0;
      mrif_q     <= 1'b0;
      spa_q      <= '0;
      maddr_q    <= '0;
      nppn_q     <= '0;
      nid_q      <= '0;
      lo_addr_q  <= '0;
      pte_addr_q <= '0;
      req_q      <= 1'b0;
      addr_q     <= '0;
    end else begin
      busy_q     <= busy_d;
      done_q     <= done_d;
      hit_q      <= hit_d;
      fault_q    <= fault_d;
      cause_q    <= cause_d;
      mrif_q     <= mrif_d;
      spa_q      <= spa_d;
      maddr_q    <= maddr_d;
      nppn_q     <= nppn_d;
      nid_q      <= nid_d;
      lo_addr_q  <= lo_addr_d;
      pte_addr_q <= pte_addr_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign hit_o       = hit_q;
  assign fault_o     = fault_q;
  assign cause_o     = cause_q;
  assign mrif_o      = mrif_q;
  assign spa_ppn_o   = spa_q;
  assign mrif_addr_o = maddr_q;
  assign mrif_nppn_o = nppn_q;
  assign mrif_nid_o  = nid_q;
  assign mem_req_o   = req_q;
  assign mem_addr_o  = addr_q;

endmodule

// File: tb/tb_iommu_msi_ptw.sv
// Self-checking bench for iommu_msi_ptw: directed cases plus randomized walks
// checked cycle by cycle against a behavioural model of the walk outcome.
module tb_iommu_msi_ptw;

  localparam int unsigned ML = 52;
  localparam int unsigned PW = 44;
  localparam int unsigned AW = 56;

  logic          clk = 1'b0;
  logic          rst_i, init_i;
  logic [ML-1:0] gppn_i, msi_mask_i, msi_pattern_i;
  logic [3:0]    msiptp_mode_i;
  logic [PW-1:0] msiptp_ppn_i;
  logic          busy_o, done_o, hit_o, fault_o, mrif_o;
  logic [11:0]   cause_o;
  logic [PW-1:0] spa_ppn_o, mrif_nppn_o;
  logic [46:0]   mrif_addr_o;
  logic [10:0]   mrif_nid_o;
  logic          mem_req_o, mem_gnt_i, mem_rvalid_i, mem_err_i;
  logic [AW-1:0] mem_addr_o;
  logic [63:0]   mem_rdata_i;

  always #5 clk = ~clk;

  iommu_msi_ptw #(.MSI_MASK_LEN(ML), .PPN_W(PW), .PA_W(AW)) dut (
    .clk_i(clk), .rst_i(rst_i), .init_i(init_i), .gppn_i(gppn_i),
    .msiptp_mode_i(msiptp_mode_i), .msiptp_ppn_i(msiptp_ppn_i),
    .msi_mask_i(msi_mask_i), .msi_pattern_i(msi_pattern_i),
    .busy_o(busy_o), .done_o(done_o), .hit_o(hit_o), .fault_o(fault_o),
    .cause_o(cause_o), .mrif_o(mrif_o), .spa_ppn_o(spa_ppn_o),
    .mrif_addr_o(mrif_addr_o), .mrif_nppn_o(mrif_nppn_o), .mrif_nid_o(mrif_nid_o),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i)
  );

  typedef struct packed {
    logic [ML-1:0] gppn;
    logic [ML-1:0] mask;
    logic [ML-1:0] pat;
    logic [3:0]    mode;
    logic [PW-1:0] ppn;
  } cfg_t;

  typedef struct packed {
    logic          hit;
    logic          fault;
    logic [11:0]   cause;
    logic          mrif;
    logic [PW-1:0] spa;
    logic [46:0]   maddr;
    logic [PW-1:0] nppn;
    logic [10:0]   nid;
    logic          two;
    logic [AW-1:0] a0;
    logic [AW-1:0] a1;
    logic [63:0]   start;
    logic [63:0]   due;
  } exp_t;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] cyc = '0;
  bit          mon_en = 1'b0;
  bit          have_last = 1'b0;
  bit          walk_hit = 1'b0;
  logic [AW-1:0] exp_addr = '0;
  exp_t        last;
  exp_t        exp_q[$];

  always @(posedge clk) cyc <= cyc + 64'd1;

  function automatic void chk(string name, logic [255:0] act, logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // Outcome of a walk computed directly from the architectural rules.
  function automatic exp_t model(cfg_t c, logic [63:0] lo, logic [63:0] hi, bit e0, bit e1);
    exp_t r;
    logic [ML-1:0] idx;
    logic [63:0] sum, sum8;
    int k;
    r = '0;
    idx = '0;
    k = 0;
    for (int i = 0; i < int'(ML); i++) begin
      if (c.mask[i]) begin
        idx[k] = c.gppn[i];
        k++;
      end
    end
    sum  = 64'(c.ppn) * 64'd4096 + 64'(idx) * 64'd16;
    sum8 = sum + 64'd8;
    r.a0 = sum[AW-1:0];
    r.a1 = sum8[AW-1:0];
    if (c.mode != 4'd1 || ((c.gppn ^ c.pat) & ~c.mask) != '0) return r;
    r.hit = 1'b1;
    if (e0) begin
      r.fault = 1'b1; r.cause = 12'd261;
    end else if (lo[0] == 1'b0) begin
      r.fault = 1'b1; r.cause = 12'd262;
    end else if (lo[2:1] == 2'd3) begin
      if (lo[63] || lo[9:3] != '0 || lo[62:54] != '0) begin
        r.fault = 1'b1; r.cause = 12'd263;
      end else begin
        r.spa = lo[53:10];
      end
    end else if (lo[2:1] == 2'd1) begin
      r.two = 1'b1;
      if (e1) begin
        r.fault = 1'b1; r.cause = 12'd261;
      end else begin
        r.mrif  = 1'b1;
        r.maddr = lo[53:7];
        r.nppn  = hi[53:10];
        r.nid   = {hi[60], hi[9:0]};
      end
    end else begin
      r.fault = 1'b1; r.cause = 12'd263;
    end
    return r;
  endfunction

  function automatic logic [255:0] res_of(exp_t e);
    return 256'({e.hit, e.fault, e.cause, e.mrif, e.spa, e.maddr, e.nppn, e.nid});
  endfunction

  function automatic logic [255:0] res_dut();
    return 256'({hit_o, fault_o, cause_o, mrif_o, spa_ppn_o, mrif_addr_o, mrif_nppn_o, mrif_nid_o});
  endfunction

  function automatic logic [255:0] dut_all();
    return 256'({busy_o, done_o, mem_req_o, mem_addr_o, hit_o, fault_o, cause_o, mrif_o,
                 spa_ppn_o, mrif_addr_o, mrif_nppn_o, mrif_nid_o});
  endfunction

  // Per-cycle compare of every observable output against the model.
  always @(negedge clk) begin
    if (mon_en && !rst_i) begin
      if (exp_q.size() == 0) chk("busy_idle", 256'(busy_o), 256'(0));
      else if (cyc > exp_q[0].start) chk("busy_walk", 256'(busy_o), 256'(1));
      if (done_o) begin
        if (exp_q.size() == 0) begin
          chk("spurious_done", 256'(done_o), 256'(0));
        end else begin
          last = exp_q.pop_front();
          have_last = 1'b1;
          chk("result", res_dut(), res_of(last));
          chk("latency", 256'(cyc), 256'(last.due));
        end
      end else if (busy_o) begin
        chk("cleared_in_walk", res_dut(), 256'(0));
      end else if (have_last) begin
        chk("result_held", res_dut(), res_of(last));
      end
      if (mem_req_o) begin
        chk("req_allowed", 256'(walk_hit), 256'(1));
        chk("req_addr", 256'(mem_addr_o), 256'(exp_addr));
      end
    end
  end

  task automatic drive_cfg(input cfg_t c);
    gppn_i = c.gppn; msi_mask_i = c.mask; msi_pattern_i = c.pat;
    msiptp_mode_i = c.mode; msiptp_ppn_i = c.ppn;
  endtask

  function automatic cfg_t rand_cfg();
    cfg_t c;
    logic [63:0] t;
    t = rnd64() & rnd64() & rnd64();
    c.mask = t[ML-1:0];
    t = rnd64(); c.pat = t[ML-1:0];
    t = rnd64();
    if ($urandom_range(0, 3) != 0) c.gppn = (c.pat & ~c.mask) | (t[ML-1:0] & c.mask);
    else c.gppn = t[ML-1:0];
    case ($urandom_range(0, 9))
      7:       c.mode = 4'd0;
      8, 9:    c.mode = 4'($urandom_range(2, 15));
      default: c.mode = 4'd1;
    endcase
    t = rnd64();
    c.ppn = ($urandom_range(0, 4) == 0) ? {PW{1'b1}} : t[PW-1:0];
    return c;
  endfunction

  // Serve one read: grant after g cycles of holding req, data r cycles after grant.
  task automatic serve(input int g, input int r, input logic [63:0] data, input bit err);
    int n;
    n = 0;
    @(negedge clk);
    while (!mem_req_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!mem_req_o) begin
      chk("req_timeout", 256'(mem_req_o), 256'(1));
      return;
    end
    for (int i = 0; i < g; i++) begin
      @(negedge clk);
      chk("req_held", 256'(mem_req_o), 256'(1));
    end
    mem_gnt_i = 1'b1;
    @(posedge clk); #1;
    mem_gnt_i = 1'b0;
    for (int i = 0; i < r; i++) begin
      mem_rdata_i = rnd64();
      mem_err_i   = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = data;
    mem_err_i    = err;
    @(posedge clk); #1;
    mem_rvalid_i = 1'b0;
    mem_err_i    = 1'b0;
  endtask

  task automatic run_walk(input cfg_t c, input logic [63:0] lo, input logic [63:0] hi,
                          input bit e0, input bit e1, input int g0, input int r0,
                          input int g1, input int r1, input bit extra);
    exp_t e;
    int n;
    e = model(c, lo, hi, e0, e1);
    @(posedge clk); #1;
    drive_cfg(c);
    init_i = 1'b1;
    e.start = cyc;
    if (!e.hit)     e.due = cyc + 64'd1;
    else if (!e.two) e.due = cyc + 64'(3 + g0 + r0);
    else            e.due = cyc + 64'(5 + g0 + r0 + g1 + r1);
    walk_hit = e.hit;
    exp_addr = e.a0;
    exp_q.push_back(e);
    @(posedge clk); #1;
    drive_cfg(rand_cfg());
    init_i = extra;
    if (extra) fork begin @(posedge clk); #1; init_i = 1'b0; end join_none
    if (e.hit) begin
      serve(g0, r0, lo, e0);
      if (e.two) begin
        exp_addr = e.a1;
        serve(g1, r1, hi, e1);
      end
    end
    n = 0;
    while (exp_q.size() != 0 && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      chk("done_timeout", 256'(exp_q.size()), 256'(0));
      exp_q.delete();
    end
    @(negedge clk);
    walk_hit = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    cfg_t c1, c;
    exp_t e;
    logic [63:0] wt, mr_lo, mr_hi, lo, hi;
    int kind, pick;

    wt    = 64'h48D1407;
    mr_lo = 64'h3 | (64'h1ABCDE << 7);
    mr_hi = (64'h1 << 60) | (64'h777 << 10) | 64'h155;
    c1.mask = 52'h7; c1.pat = 52'h28000; c1.gppn = 52'h28005;
    c1.mode = 4'd1;  c1.ppn = 44'h80000;

    rst_i = 1'b1; init_i = 1'b0;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_err_i = 1'b0; mem_rdata_i = '0;
    drive_cfg(c1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", dut_all(), 256'(0));
    @(posedge clk); #1;
    rst_i  = 1'b0;
    mon_en = 1'b1;

    e = model(c1, wt, 64'h0, 1'b0, 1'b0);
    chk("model_addr0", 256'(e.a0), 256'(56'h80000050));
    chk("model_spa", 256'(e.spa), 256'(44'h12345));
    e = model(c1, mr_lo, mr_hi, 1'b0, 1'b0);
    chk("model_addr1", 256'(e.a1), 256'(56'h80000058));
    chk("model_nid", 256'(e.nid), 256'(11'h555));

    run_walk(c1, wt, 64'h0, 1'b0, 1'b0, 0, 0, 0, 0, 1'b0);
    chk("lit_wt", 256'({hit_o, fault_o, mrif_o, spa_ppn_o}), 256'({3'b100, 44'h12345}));

    c = c1; c.gppn = 52'h29005;
    run_walk(c, wt, 64'h0, 1'b0, 1'b0, 0, 0, 0, 0, 1'b0);
    chk("lit_miss", 256'(hit_o), 256'(0));
    c = c1; c.mode = 4'd0;
    run_walk(c, wt, 64'h0, 1'b0, 1'b0, 0, 0, 0, 0, 1'b0);
    chk("lit_mode_off", 256'(hit_o), 256'(0));

    run_walk(c1, 64'h0, 64'h0, 1'b0, 1'b0, 0, 0, 0, 0, 1'b0);
    chk("lit_invalid", 256'({fault_o, cause_o}), 256'({1'b1, 12'd262}));
    run_walk(c1, 64'h5, 64'h0, 1'b0, 1'b0, 0, 1, 0, 0, 1'b0);
    chk("lit_m2", 256'({fault_o, cause_o}), 256'({1'b1, 12'd263}));
    run_walk(c1, wt, 64'h0, 1'b1, 1'b0, 1, 0, 0, 0, 1'b0);
    chk("lit_err0", 256'({fault_o, cause_o}), 256'({1'b1, 12'd261}));

    run_walk(c1, mr_lo, mr_hi, 1'b0, 1'b0, 0, 0, 0, 0, 1'b0);
    chk("lit_mrif", 256'({mrif_o, mrif_addr_o, mrif_nppn_o, mrif_nid_o}),
        256'({1'b1, 47'h1ABCDE, 44'h777, 11'h555}));

    run_walk(c1, wt, 64'h0, 1'b0, 1'b0, 5, 0, 0, 0, 1'b1);
    chk("lit_stall_spa", 256'(spa_ppn_o), 256'(44'h12345));

    // Reset while the first read is outstanding; the late response must be dropped.
    mon_en = 1'b0;
    @(posedge clk); #1;
    drive_cfg(c1);
    init_i = 1'b1;
    @(posedge clk); #1;
    init_i = 1'b0;
    @(negedge clk);
    chk("rst_walk_req", 256'(mem_req_o), 256'(1));
    mem_gnt_i = 1'b1;
    @(posedge clk); #1;
    mem_gnt_i = 1'b0;
    rst_i = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0;
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = wt;
    @(negedge clk);
    chk("rst_drop", dut_all(), 256'(0));
    @(posedge clk); #1;
    mem_rvalid_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rst_stay_idle", dut_all(), 256'(0));
    end
    exp_q.delete();
    have_last = 1'b0;
    walk_hit  = 1'b0;
    mon_en    = 1'b1;
    run_walk(c1, wt, 64'h0, 1'b0, 1'b0, 0, 0, 0, 0, 1'b0);
    chk("post_rst_spa", 256'({hit_o, spa_ppn_o}), 256'({1'b1, 44'h12345}));

    for (int n = 0; n < 80; n++) begin
      c  = rand_cfg();
      hi = rnd64();
      kind = int'($urandom_range(0, 4));
      lo = rnd64();
      case (kind)
        0, 1: begin
          lo = {10'b0, lo[43:0], 7'b0, 3'b111};
          if (kind == 1) begin
            pick = int'($urandom_range(0, 16));
            if (pick == 0)     lo[63] = 1'b1;
            else if (pick < 8) lo[2 + pick] = 1'b1;
            else               lo[46 + pick] = 1'b1;
          end
        end
        2: lo[2:0] = 3'b011;
        3: lo[0] = 1'b0;
        default: begin
          lo[0] = 1'b1;
          lo[2:1] = ($urandom_range(0, 1) == 0) ? 2'd0 : 2'd2;
        end
      endcase
      run_walk(c, lo, hi, ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0),
               int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
               int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
               ($urandom_range(0, 3) == 0));
    end

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
